lfsr_keystream_engine: RTL

Parametrised LFSR keystream source for the pixel-scrambling path of the VGA pipeline. It produces one WIDTH-bit key word per valid/ready handshake, for XOR with RGB pixel data. It supports a programmable seed, Fibonacci or Galois stepping, multiple LFSR steps per word, a warm-up run after each reseed, and detection and recovery of the all-zero lock-up state. It sits between the frame timing controller, which issues `frame_start`, and the pixel XOR stage, which is the key consumer.

---
 rtl/lfsr_pkg.sv | 20 ++
 rtl/lfsr_keystream_engine_step.sv | 22 ++
 rtl/lfsr_keystream_engine.sv | 132 +++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants and types for the pixel-scrambling LFSR keystream engine.
package lfsr_pkg;

  localparam int unsigned RGB_WIDTH    = 12;
  localparam logic [RGB_WIDTH-1:0] RGB_TAPS = 12'h829;
  localparam logic [RGB_WIDTH-1:0] RGB_SEED = 12'hCCC;

  localparam int unsigned WARMUP_CNT_W = 8;

  localparam int unsigned STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] ST_WARMUP = 2'd1;
  localparam logic [STATE_W-1:0] ST_RUN    = 2'd2;

  typedef enum logic {
    MODE_FIBONACCI = 1'b0,
    MODE_GALOIS    = 1'b1
  } lfsr_mode_e;

endpackage

// File: rtl/lfsr_keystream_engine_step.sv
// Combinational single LFSR step, Fibonacci or Galois, selected by mode.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = RGB_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(RGB_TAPS)
) (
  input  logic [WIDTH-1:0] state,
  input  logic             mode,
  output logic [WIDTH-1:0] next
);

  always_comb begin
    next = '0;
    if (mode == 1'(MODE_GALOIS)) begin
      next = (state >> 1) ^ ({WIDTH{state[0]}} & TAPS);
    end else begin
      next = {^(state & TAPS), state[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/lfsr_keystream_engine.sv
// LFSR keystream source: reseed/warm-up FSM, multi-step word advance,
// zero-state substitution and valid/ready key delivery.
module lfsr_keystream_engine
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH          = RGB_WIDTH,
  parameter logic [WIDTH-1:0] TAPS           = WIDTH'(RGB_TAPS),
  parameter logic [WIDTH-1:0] DEFAULT_SEED   = WIDTH'(RGB_SEED),
  parameter int unsigned      WARMUP_CYCLES  = 0,
  parameter int unsigned      STEPS_PER_WORD = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             frame_start,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             mode,
  input  logic             key_ready,
  output logic             key_valid,
  output logic [WIDTH-1:0] key_data,
  output logic             busy,
  output logic             seed_err,
  output logic             lockup_err
);

  localparam logic [STATE_W-1:0] LOAD_STATE = (WARMUP_CYCLES > 0) ? ST_WARMUP : ST_RUN;

  logic [STATE_W-1:0]      state_q, state_d;
  logic [WIDTH-1:0]        lfsr_q, lfsr_d;
  logic                    mode_q, mode_d;
  logic [WARMUP_CNT_W-1:0] cnt_q, cnt_d;
  logic                    key_valid_q, key_valid_d;
  logic                    busy_q, busy_d;
  logic                    seed_err_q, seed_err_d;
  logic                    lockup_err_q, lockup_err_d;

  logic                    load;
  logic [WIDTH-1:0]        load_val;
  logic                    advance;
  logic [WIDTH-1:0]        chain [0:STEPS_PER_WORD];

  // Word advance: STEPS_PER_WORD single steps chained in one cycle.
  assign chain[0] = lfsr_q;
  for (genvar i = 0; i < STEPS_PER_WORD; i++) begin : g_step
    lfsr_step #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
    ) u_step (
      .state (chain[i]),
      .mode  (mode_q),
      .next  (chain[i+1])
    );
  end

  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    mode_d       = mode_q;
    cnt_d        = cnt_q;
    key_valid_d  = 1'b0;
    busy_d       = 1'b0;
    seed_err_d   = 1'b0;
    lockup_err_d = lockup_err_q;
    advance      = 1'b0;
    load         = seed_load | frame_start;
    load_val     = seed_load ? seed_in : DEFAULT_SEED;

    if (load) begin
      // A load always wins over the handshake; the response cycle is never valid.
      lfsr_d     = (load_val == '0) ? DEFAULT_SEED : load_val;
      seed_err_d = (load_val == '0);
      mode_d     = mode;
      cnt_d      = WARMUP_CNT_W'(WARMUP_CYCLES);
      state_d    = LOAD_STATE;
      if (seed_load) lockup_err_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_WARMUP: begin
          busy_d  = 1'b1;
          advance = busy_q;
          cnt_d   = cnt_q - WARMUP_CNT_W'(1);
          if (cnt_q <= WARMUP_CNT_W'(1)) state_d = ST_RUN;
        end
        ST_RUN: begin
          key_valid_d = 1'b1;
          advance     = key_valid_q & key_ready;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Never let the register settle in the all-zero lock-up state.
    if (advance) begin
      if (chain[STEPS_PER_WORD] == '0) begin
        lfsr_d       = DEFAULT_SEED;
        lockup_err_d = 1'b1;
      end else begin
        lfsr_d = chain[STEPS_PER_WORD];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      lfsr_q       <= DEFAULT_SEED;
      mode_q       <= 1'b0;
      cnt_q        <= '0;
      key_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      seed_err_q   <= 1'b0;
      lockup_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      mode_q       <= mode_d;
      cnt_q        <= cnt_d;
      key_valid_q  <= key_valid_d;
      busy_q       <= busy_d;
      seed_err_q   <= seed_err_d;
      lockup_err_q <= lockup_err_d;
    end
  end

  assign key_valid  = key_valid_q;
  assign key_data   = lfsr_q;
  assign busy       = busy_q;
  assign seed_err   = seed_err_q;
  assign lockup_err = lockup_err_q;

endmodule
